// File: rtl/fifo_rd_packer.sv
// Read-side consumer for the async FIFO: issues credit-limited reads, absorbs the
// fixed read latency in a skid buffer and packs bytes little-endian into words.
module fifo_rd_packer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned PACK       = 4,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_rempty,
  output logic                    fifo_rinc,
  input  logic [WIDTH-1:0]        fifo_rdata,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*PACK-1:0]   out_data,
  output logic [$clog2(PACK):0]   out_cnt,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned IDX_W = $clog2(PACK) + 1;
  localparam int unsigned OUT_W = WIDTH * PACK;

  logic [RD_LAT-1:0] vp_q, vp_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  mem_q [SKID_DEPTH];
  logic [WIDTH-1:0]  mem_d [SKID_DEPTH];
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              busy_q, busy_d;

  logic [CNT_W:0]    credit_used;
  logic              capture;
  logic              pop;
  logic [WIDTH-1:0]  pop_byte;
  logic [OUT_W-1:0]  lane_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit covers both bytes still in the read pipe and bytes parked in the skid buffer.
  assign credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
  assign fifo_rinc   = rst_n && !fifo_rempty && !flush_pend_q &&
                       (credit_used < (CNT_W+1)'(SKID_DEPTH));
  assign capture     = vp_q[RD_LAT-1];
  assign pop         = (occ_q != '0) && (!out_valid_q || out_ready);
  assign pop_byte    = mem_q[rd_ptr_q];

  always_comb begin
    vp_d         = vp_q;
    inflight_d   = inflight_q;
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_cnt_d    = out_cnt_q;
    flush_pend_d = flush_pend_q;
    lane_word    = acc_q;

    vp_d[0] = fifo_rinc;
    for (int unsigned i = 1; i < RD_LAT; i++) vp_d[i] = vp_q[i-1];

    case ({fifo_rinc, capture})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (capture) begin
      mem_d[wr_ptr_q] = fifo_rdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({capture, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (flush && !flush_pend_q) flush_pend_d = 1'b1;

    if (pop) begin
      for (int unsigned k = 0; k < PACK; k++) begin
        if (IDX_W'(k) == idx_q) lane_word[k*WIDTH +: WIDTH] = pop_byte;
      end
      if (idx_q == IDX_W'(PACK - 1)) begin
        out_data_d  = lane_word;
        out_cnt_d   = IDX_W'(PACK);
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
      end else begin
        acc_d = lane_word;
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (flush_pend_q && (inflight_q == '0) && (occ_q == '0) && !out_valid_q) begin
      // Drain point reached: emit the partial word, if any, and end the flush.
      flush_pend_d = 1'b0;
      if (idx_q != '0) begin
        out_data_d  = acc_q;
        out_cnt_d   = idx_q;
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
      end
    end

    busy_d = (inflight_d != '0) || (occ_d != '0) || (idx_d != '0) ||
             out_valid_d || flush_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_q         <= '0;
      inflight_q   <= '0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      vp_q         <= vp_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
      flush_pend_q <= flush_pend_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign busy      = busy_q;

endmodule
